hazard_fwd_unit: RTL and testbench

//  Parametrised hazard detection and operand forwarding for the 5-stage pipeline.

---
 rtl/pipeline_pkg.sv | 24 ++
 rtl/fwd_match.sv | 50 +++++
 rtl/hazard_fwd_unit.sv | 122 ++++++++++++
 tb/tb_hazard_fwd_unit.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard/forwarding logic.
//   FWD_*        2-bit operand forward-select codes
//   hfu_state_t  load-use stall FSM states
//   clog2        ceil(log2(value)) for sizing counters at elaboration time
package pipeline_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;  // register file read
  localparam logic [1:0] FWD_MEM = 2'b01;  // MEM-stage ALU result
  localparam logic [1:0] FWD_WB  = 2'b10;  // WB-stage busW
  localparam logic [1:0] FWD_RET = 2'b11;  // retired-writeback latch

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } hfu_state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 0;
    while ((64'd1 << w) < 64'(value)) w++;
    return w;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-source producer comparison.
//   cons_valid            consumer instruction is real
//   src / src_use         source register and whether it is read
//   mem_v/mem_rw          MEM producer tag (valid & regwrite folded in)
//   mem_is_load           MEM producer is a load
//   wb_v/wb_rw            WB producer tag
//   ret_v/ret_rw          retired-writeback latch tag
//   sel                   forward select, priority MEM > WB > retired > regfile
//   load_hit              source depends on the load currently in MEM
module fwd_match
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              cons_valid,
  input  logic [REG_AW-1:0] src,
  input  logic              src_use,
  input  logic              mem_v,
  input  logic [REG_AW-1:0] mem_rw,
  input  logic              mem_is_load,
  input  logic              wb_v,
  input  logic [REG_AW-1:0] wb_rw,
  input  logic              ret_v,
  input  logic [REG_AW-1:0] ret_rw,
  output logic [1:0]        sel,
  output logic              load_hit
);

  logic live;
  logic hit_mem;
  logic hit_wb;
  logic hit_ret;

  // register 0 is hard-wired, so it never creates a dependency when ZERO_REG is set
  assign live    = cons_valid & src_use & ~(ZERO_REG && (src == '0));
  assign hit_mem = live & mem_v & (src == mem_rw);
  assign hit_wb  = live & wb_v  & (src == wb_rw);
  assign hit_ret = live & ret_v & (src == ret_rw);

  always_comb begin
    sel = FWD_RF;
    if (hit_mem)      sel = FWD_MEM;
    else if (hit_wb)  sel = FWD_WB;
    else if (hit_ret) sel = FWD_RET;
  end

  assign load_hit = hit_mem & mem_is_load;

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding for the 5-stage pipeline.
//   clock, reset          rising-edge clock, synchronous active-high reset
//   ext_stall             whole-pipe freeze; holds FSM, retired latch and counter
//   cons_*                EX-stage consumer: valid, packed sources, per-source use
//   mem_*                 MEM-stage producer tag and load flag
//   wb_*                  WB-stage producer tag
//   fwd_sel               per-source 2-bit forward select
//   stall                 hold IF/ID/EX
//   bubble                inject a NOP into MEM
//   stall_cnt             saturating count of cycles with stall & !ext_stall
module hazard_fwd_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned LOAD_LAT = 1,
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ext_stall,
  input  logic                      cons_valid,
  input  logic [NUM_SRC*REG_AW-1:0] cons_src,
  input  logic [NUM_SRC-1:0]        cons_use,
  input  logic                      mem_valid,
  input  logic [REG_AW-1:0]         mem_rw,
  input  logic                      mem_regwrite,
  input  logic                      mem_is_load,
  input  logic                      wb_valid,
  input  logic [REG_AW-1:0]         wb_rw,
  input  logic                      wb_regwrite,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      stall,
  output logic                      bubble,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int unsigned LAT_W = clog2(LOAD_LAT + 1);

  hfu_state_t           state, state_nxt;
  logic [LAT_W-1:0]     cnt, cnt_nxt;
  logic                 ret_v;
  logic [REG_AW-1:0]    ret_rw;
  logic                 mem_v;
  logic                 wb_v;
  logic [NUM_SRC-1:0]   load_hit;
  logic [NUM_SRC*2-1:0] sel_raw;
  logic                 hz;
  logic                 stall_fsm;

  assign mem_v = mem_valid & mem_regwrite;
  assign wb_v  = wb_valid & wb_regwrite;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_match #(
      .REG_AW  (REG_AW),
      .ZERO_REG(ZERO_REG)
    ) u_match (
      .cons_valid (cons_valid),
      .src        (cons_src[g*REG_AW +: REG_AW]),
      .src_use    (cons_use[g]),
      .mem_v      (mem_v),
      .mem_rw     (mem_rw),
      .mem_is_load(mem_is_load),
      .wb_v       (wb_v),
      .wb_rw      (wb_rw),
      .ret_v      (ret_v),
      .ret_rw     (ret_rw),
      .sel        (sel_raw[g*2 +: 2]),
      .load_hit   (load_hit[g])
    );
  end

  // several sources hitting the same load still produce a single stall sequence
  assign hz = |load_hit;

  // The first stall cycle is spent in IDLE; HOLD covers the remaining LOAD_LAT-1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_fsm = 1'b0;
    case (state)
      IDLE: begin
        stall_fsm = hz;
        if (hz && !ext_stall && (LOAD_LAT > 1)) begin
          state_nxt = HOLD;
          cnt_nxt   = LAT_W'(LOAD_LAT - 1);
        end
      end
      HOLD: begin
        stall_fsm = 1'b1;
        if (!ext_stall) begin
          cnt_nxt = cnt - 1'b1;
          if (cnt_nxt == '0) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign stall   = stall_fsm & ~reset;
  assign bubble  = stall & ~ext_stall;
  assign fwd_sel = reset ? '0 : sel_raw;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      ret_v     <= 1'b0;
      ret_rw    <= '0;
      stall_cnt <= '0;
    end else if (!ext_stall) begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      ret_v  <= wb_v;
      ret_rw <= wb_rw;
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: three configurations share one
// stimulus stream (k=0: LOAD_LAT=1; k=1: LOAD_LAT=2; k=2: LOAD_LAT=1,
// ZERO_REG=0, CNT_W=4). A reference model tracks owed stall cycles, the
// retired writeback and the saturating counter per configuration.
module tb_hazard_fwd_unit;
  import pipeline_pkg::*;

  localparam int unsigned AW = 5;
  localparam int unsigned NS = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ext_stall = 1'b0;
  logic          cons_valid = 1'b0;
  logic [NS*AW-1:0] cons_src = '0;
  logic [NS-1:0] cons_use = '0;
  logic          mem_valid = 1'b0;
  logic [AW-1:0] mem_rw = '0;
  logic          mem_regwrite = 1'b0;
  logic          mem_is_load = 1'b0;
  logic          wb_valid = 1'b0;
  logic [AW-1:0] wb_rw = '0;
  logic          wb_regwrite = 1'b0;

  logic [NS*2-1:0] sel_a, sel_b, sel_c;
  logic            stall_a, stall_b, stall_c;
  logic            bubble_a, bubble_b, bubble_c;
  logic [15:0]     cnt_a, cnt_b;
  logic [3:0]      cnt_c;

  int checks = 0;
  int failures = 0;

  int unsigned   m_rem  [3];
  logic          m_retv [3];
  logic [AW-1:0] m_retrw[3];
  int unsigned   m_cnt  [3];

  always #5 clock = ~clock;

  hazard_fwd_unit #(.REG_AW(AW), .NUM_SRC(NS), .LOAD_LAT(1), .ZERO_REG(1'b1), .CNT_W(16)) u_a (
    .clock(clock), .reset(reset), .ext_stall(ext_stall), .cons_valid(cons_valid),
    .cons_src(cons_src), .cons_use(cons_use), .mem_valid(mem_valid), .mem_rw(mem_rw),
    .mem_regwrite(mem_regwrite), .mem_is_load(mem_is_load), .wb_valid(wb_valid),
    .wb_rw(wb_rw), .wb_regwrite(wb_regwrite), .fwd_sel(sel_a), .stall(stall_a),
    .bubble(bubble_a), .stall_cnt(cnt_a));

  hazard_fwd_unit #(.REG_AW(AW), .NUM_SRC(NS), .LOAD_LAT(2), .ZERO_REG(1'b1), .CNT_W(16)) u_b (
    .clock(clock), .reset(reset), .ext_stall(ext_stall), .cons_valid(cons_valid),
    .cons_src(cons_src), .cons_use(cons_use), .mem_valid(mem_valid), .mem_rw(mem_rw),
    .mem_regwrite(mem_regwrite), .mem_is_load(mem_is_load), .wb_valid(wb_valid),
    .wb_rw(wb_rw), .wb_regwrite(wb_regwrite), .fwd_sel(sel_b), .stall(stall_b),
    .bubble(bubble_b), .stall_cnt(cnt_b));

  hazard_fwd_unit #(.REG_AW(AW), .NUM_SRC(NS), .LOAD_LAT(1), .ZERO_REG(1'b0), .CNT_W(4)) u_c (
    .clock(clock), .reset(reset), .ext_stall(ext_stall), .cons_valid(cons_valid),
    .cons_src(cons_src), .cons_use(cons_use), .mem_valid(mem_valid), .mem_rw(mem_rw),
    .mem_regwrite(mem_regwrite), .mem_is_load(mem_is_load), .wb_valid(wb_valid),
    .wb_rw(wb_rw), .wb_regwrite(wb_regwrite), .fwd_sel(sel_c), .stall(stall_c),
    .bubble(bubble_c), .stall_cnt(cnt_c));

  function automatic int unsigned lat_of(input int k);
    return (k == 1) ? 2 : 1;
  endfunction

  function automatic bit zr_of(input int k);
    return (k == 2) ? 1'b0 : 1'b1;
  endfunction

  function automatic int unsigned cmax_of(input int k);
    return (k == 2) ? 15 : 65535;
  endfunction

  function automatic logic [NS*2-1:0] obs_sel(input int k);
    return (k == 0) ? sel_a : (k == 1) ? sel_b : sel_c;
  endfunction

  function automatic logic obs_stall(input int k);
    return (k == 0) ? stall_a : (k == 1) ? stall_b : stall_c;
  endfunction

  function automatic logic obs_bubble(input int k);
    return (k == 0) ? bubble_a : (k == 1) ? bubble_b : bubble_c;
  endfunction

  function automatic logic [15:0] obs_cnt(input int k);
    return (k == 0) ? cnt_a : (k == 1) ? cnt_b : {12'h000, cnt_c};
  endfunction

  // Which producer source i of configuration k should read from.
  function automatic logic [1:0] ref_sel(input int k, input int i);
    logic [AW-1:0] s;
    s = cons_src[i*AW +: AW];
    if (reset) return FWD_RF;
    if (!cons_valid || !cons_use[i]) return FWD_RF;
    if (zr_of(k) && s == 0) return FWD_RF;
    if (mem_valid && mem_regwrite && mem_rw == s) return FWD_MEM;
    if (wb_valid && wb_regwrite && wb_rw == s) return FWD_WB;
    if (m_retv[k] && m_retrw[k] == s) return FWD_RET;
    return FWD_RF;
  endfunction

  function automatic bit ref_hz(input int k);
    bit h;
    h = 1'b0;
    for (int i = 0; i < NS; i++)
      if (ref_sel(k, i) == FWD_MEM && mem_is_load) h = 1'b1;
    return h;
  endfunction

  function automatic bit ref_stall(input int k);
    return !reset && (m_rem[k] != 0 || ref_hz(k));
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    logic [NS*2-1:0] so;
    for (int k = 0; k < 3; k++) begin
      so = obs_sel(k);
      for (int i = 0; i < NS; i++)
        chk($sformatf("m%0d_sel%0d", k, i), 16'(so[i*2 +: 2]), 16'(ref_sel(k, i)));
      chk($sformatf("m%0d_stall", k), 16'(obs_stall(k)), 16'(ref_stall(k)));
      chk($sformatf("m%0d_bubble", k), 16'(obs_bubble(k)), 16'(ref_stall(k) && !ext_stall));
      chk($sformatf("m%0d_cnt", k), obs_cnt(k), 16'(m_cnt[k]));
    end
  endtask

  task automatic model_update();
    bit st;
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        m_rem[k] = 0; m_retv[k] = 1'b0; m_retrw[k] = '0; m_cnt[k] = 0;
      end else if (!ext_stall) begin
        st = ref_stall(k);
        if (st && m_cnt[k] < cmax_of(k)) m_cnt[k]++;
        if (m_rem[k] != 0) m_rem[k]--;
        else if (ref_hz(k)) m_rem[k] = lat_of(k) - 1;
        m_retv[k]  = wb_valid & wb_regwrite;
        m_retrw[k] = wb_rw;
      end
    end
  endtask

  task automatic settle();
    @(negedge clock);
    model_check();
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic quiet();
    ext_stall = 0; cons_valid = 0; cons_src = '0; cons_use = '0;
    mem_valid = 0; mem_rw = '0; mem_regwrite = 0; mem_is_load = 0;
    wb_valid = 0; wb_rw = '0; wb_regwrite = 0;
  endtask

  task automatic set_src(input logic [AW-1:0] s0, input logic [AW-1:0] s1);
    cons_src = {s1, s0};
  endtask

  initial begin
    logic [NS*2-1:0] s;
    for (int k = 0; k < 3; k++) begin
      m_rem[k] = 0; m_retv[k] = 0; m_retrw[k] = '0; m_cnt[k] = 0;
    end
    tick();
    settle();
    chk("reset_stall", 16'(stall_b), 16'd0);
    chk("reset_sel", 16'(sel_a), 16'd0);
    tick();
    reset = 0;
    settle();
    chk("reset_cnt", cnt_a, 16'd0);
    tick();

    // Non-load MEM producer forwards without stalling
    quiet(); cons_valid = 1; cons_use = 2'b11; set_src(5'd3, 5'd1);
    mem_valid = 1; mem_regwrite = 1; mem_rw = 5'd3;
    settle();
    s = sel_a; chk("t1_sel0", 16'(s[1:0]), 16'(2'b01));
    chk("t1_stall", 16'(stall_a), 16'd0);
    tick();

    // MEM beats WB, then WB, then the retired latch
    set_src(5'd1, 5'd7); mem_rw = 5'd7; wb_valid = 1; wb_regwrite = 1; wb_rw = 5'd7;
    settle();
    s = sel_a; chk("t2_mem_sel1", 16'(s[3:2]), 16'(2'b01));
    tick();
    mem_rw = 5'd9;
    settle();
    s = sel_a; chk("t2_wb_sel1", 16'(s[3:2]), 16'(2'b10));
    tick();
    wb_rw = 5'd12;
    settle();
    s = sel_a; chk("t2_ret_sel1", 16'(s[3:2]), 16'(2'b11));
    tick();

    // Load-use, LOAD_LAT 1 and 2, with ext_stall in HOLD
    quiet(); reset = 1; tick(); reset = 0;
    cons_valid = 1; cons_use = 2'b01; set_src(5'd5, 5'd0);
    mem_valid = 1; mem_regwrite = 1; mem_is_load = 1; mem_rw = 5'd5;
    settle();
    chk("t3_stall_a", 16'(stall_a), 16'd1);
    chk("t3_bubble_a", 16'(bubble_a), 16'd1);
    chk("t4_stall_b", 16'(stall_b), 16'd1);
    tick();
    mem_valid = 0; mem_is_load = 0; wb_valid = 1; wb_regwrite = 1; wb_rw = 5'd5;
    ext_stall = 1;
    settle();
    chk("t3_stall_a_done", 16'(stall_a), 16'd0);
    chk("t3_cnt_a", cnt_a, 16'd1);
    s = sel_a; chk("t3_sel_wb", 16'(s[1:0]), 16'(2'b10));
    chk("t4_hold_stall", 16'(stall_b), 16'd1);
    chk("t4_hold_bubble", 16'(bubble_b), 16'd0);
    tick();
    ext_stall = 0;
    settle();
    chk("t4_hold_kept", 16'(stall_b), 16'd1);
    chk("t4_cnt_frozen", cnt_b, 16'd1);
    tick();
    wb_valid = 0; wb_regwrite = 0;
    settle();
    chk("t4_release", 16'(stall_b), 16'd0);
    s = sel_b; chk("t4_sel_ret", 16'(s[1:0]), 16'(2'b11));
    chk("t4_cnt_b", cnt_b, 16'd2);
    tick();

    // Register 0 load hazard only matters with ZERO_REG=0
    quiet(); cons_valid = 1; cons_use = 2'b01; set_src(5'd0, 5'd4);
    mem_valid = 1; mem_regwrite = 1; mem_is_load = 1; mem_rw = 5'd0;
    settle();
    s = sel_a; chk("t5_sel_r0", 16'(s[1:0]), 16'd0);
    chk("t5_stall_r0", 16'(stall_a), 16'd0);
    chk("t5_stall_nozr", 16'(stall_c), 16'd1);
    tick();

    // Reset in HOLD clears FSM, counter and retired latch
    set_src(5'd5, 5'd0); mem_rw = 5'd5;
    wb_valid = 1; wb_regwrite = 1; wb_rw = 5'd6;
    settle();
    tick();
    reset = 1;
    settle();
    chk("t6_stall_in_reset", 16'(stall_b), 16'd0);
    chk("t6_bubble_in_reset", 16'(bubble_b), 16'd0);
    tick();
    reset = 0; quiet(); cons_valid = 1; cons_use = 2'b01; set_src(5'd6, 5'd0);
    settle();
    chk("t6_stall_after", 16'(stall_b), 16'd0);
    chk("t6_cnt_after", cnt_b, 16'd0);
    s = sel_b; chk("t6_ret_cleared", 16'(s[1:0]), 16'd0);
    tick();

    // Counter saturation on the 4-bit configuration
    set_src(5'd2, 5'd0); mem_valid = 1; mem_regwrite = 1; mem_is_load = 1; mem_rw = 5'd2;
    for (int n = 0; n < 20; n++) begin
      settle();
      tick();
    end
    settle();
    chk("t6_sat_c", obs_cnt(2), 16'h000F);
    chk("t6_cnt_a20", cnt_a, 16'd20);
    tick();
    settle();
    chk("t6_sat_hold", obs_cnt(2), 16'h000F);
    tick();

    // Randomized traffic over a small register set
    for (int n = 0; n < 500; n++) begin
      reset        = ($urandom_range(0, 39) == 0);
      ext_stall    = ($urandom_range(0, 3) == 0);
      cons_valid   = ($urandom_range(0, 7) != 0);
      cons_use     = NS'($urandom);
      set_src(AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)));
      mem_valid    = ($urandom_range(0, 3) != 0);
      mem_regwrite = ($urandom_range(0, 3) != 0);
      mem_is_load  = ($urandom_range(0, 1) != 0);
      mem_rw       = AW'($urandom_range(0, 3));
      wb_valid     = ($urandom_range(0, 3) != 0);
      wb_regwrite  = ($urandom_range(0, 3) != 0);
      wb_rw        = AW'($urandom_range(0, 3));
      settle();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
